prefix_adder_rr_arbiter: RTL and testbench
==========================================

// Module: prefix_adder_rr_arbiter
// PURPOSE
//  Shares one combinational 16-bit 5-level prefix adder core among NREQ requesters.
//  Round-robin arbitration picks at most one requester per cycle and drives its operands into the core.
//  The sum, carry-out and requester ID are captured in a single output register with a valid/ready handshake.
//  Sits between the operand-producing clients and the shared adder datapath.
// PARAMETERS
//  NREQ    4   number of requesters, 2..8
//  IDW     2   requester-ID width, = clog2(NREQ)
//  CNTW    16  width of the issued-operation counter
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   NREQ      per-requester operand valid
//  req_ready  out  NREQ      per-requester accept, one-hot or zero
//  req_a      in   NREQ*16   operand A; requester i uses bits [16i+15:16i]
//  req_b      in   NREQ*16   operand B, same packing as req_a
//  rsp_valid  out  1         result register holds a result
//  rsp_ready  in   1         consumer accepts the result
//  rsp_sum    out  16        registered sum
//  rsp_cout   out  1         registered carry-out
//  rsp_id     out  IDW       index of the requester that owns the result
//  op_count   out  CNTW      number of operations issued, wraps modulo 2^CNTW
// BEHAVIOUR
//  Reset (async assert, sync deassert release):
//   - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, op_count=0.
//   - Round-robin pointer rr_ptr=0, so requester 0 has highest priority.
//  Output register state:
//   - EMPTY when rsp_valid=0; FULL when rsp_valid=1.
//   - can_issue = !rsp_valid || rsp_ready. This allows pass-through at full throughput.
//  Grant:
//   - Scan from rr_ptr upward, modulo NREQ. The first i with req_valid[i]=1 is the winner.
//   - req_ready[i] = can_issue && (i == winner). req_ready is combinational from req_valid, rsp_valid and rsp_ready.
//   - When no request is pending, or can_issue=0, req_ready is all-zero.
//  Issue (a transfer occurs when req_valid[i] && req_ready[i]):
//   - Core inputs are req_a/req_b of the winner; core inputs are zero when no grant.
//   - Next edge: rsp_sum <= core sum, rsp_cout <= core cout, rsp_id <= winner, rsp_valid <= 1.
//   - rr_ptr <= (winner+1) mod NREQ. op_count <= op_count+1, wrapping.
//   - Latency is 1 cycle, from the accepted request edge to rsp_valid=1.
//  Drain:
//   - On rsp_valid && rsp_ready with no new issue in the same cycle: rsp_valid <= 0.
//   - The data fields hold their last value.
//  Simultaneous drain and issue: the new result replaces the old one in the same edge, and rsp_valid stays 1.
//  Backpressure: while rsp_valid=1 and rsp_ready=0:
//   - No grant; req_ready is all-zero.
//   - rr_ptr, op_count and all rsp_* fields hold.
//  Requesters must hold req_a/req_b stable while req_valid=1 and the request is not yet accepted.
//  The arbiter never drops or duplicates a request.
//  Fairness: any continuously valid requester is granted within NREQ issue opportunities.
//  Reset mid-operation discards any held result and returns the block to the reset state; no response is emitted for it.
//  Arithmetic: {rsp_cout, rsp_sum} = a + b, unsigned, with no carry-in.
// STRUCTURE
//  Shared package prefix_adder_pkg:
//   - localparam ADDER_W=16.
//   - Function rr_pick(valid, ptr), returning the winner index and a found flag.
//  One sub-module instance: adder_16b_5l, the shared combinational core.
//  Everything else is inline: rr pointer, output register, counter.
// TESTING
//  1. Reset; NREQ=4; only req0 valid with a=16'h00FF, b=16'h0001 and rsp_ready=1.
//     -> req_ready=4'b0001; next cycle rsp_sum=16'h0100, rsp_cout=0, rsp_id=0, op_count=1.
//  2. All 4 requests valid continuously; rsp_ready=1.
//     -> grants 0,1,2,3,0 on consecutive cycles; one result per cycle; op_count=5 after 5 cycles.
//  3. a=16'hFFFF, b=16'h0001 -> rsp_sum=16'h0000, rsp_cout=1.
//     a=16'h8000, b=16'h8000 -> rsp_sum=0, rsp_cout=1.
//  4. rsp_ready=0 with rsp_valid=1 for 3 cycles while req2 is valid.
//     -> req_ready=0 and rsp_* stable; on rsp_ready=1, req2 is granted the same cycle and its result appears next cycle.
//  5. rst_n pulsed low while rsp_valid=1 and requests are pending.
//     -> rsp_valid=0, op_count=0 immediately; after release, requester 0 has priority.
//  6. Preload op_count=16'hFFFF (force), then issue one request.
//     -> op_count wraps to 0 and rsp_valid=1.

Source files
------------

// File: rtl/prefix_adder_pkg.sv
// Shared definitions for the prefix-adder arbiter: datapath width and round-robin pick helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prefix_adder_pkg;

    localparam int ADDER_W = 16;
    // The pick helper works on a fixed 8-lane vector; narrower request sets are zero-extended.
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // Scan nreq lanes starting at ptr, wrapping modulo nreq; first valid lane wins.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input logic [2:0]         ptr,
                                      input int                 nreq);
        pick_t r;
        int    cand;
        r = '0;
        for (int off = 0; off < MAX_REQ; off++) begin
            cand = (int'(ptr) + off) % nreq;
            if (off < nreq && !r.found && valid[cand]) begin
                r.found = 1'b1;
                r.idx   = 3'(cand);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_16b_5l.sv
// Combinational 16-bit Kogge-Stone adder; five prefix levels over 17 positions (carry-in slot + 16 bits).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; inputs a, b; outputs sum, cout.
module adder_16b_5l
    import prefix_adder_pkg::*;
(
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    output logic [ADDER_W-1:0] sum,
    output logic               cout
);

    // Position 0 is the (zero) carry-in; position k+1 carries bit k. With 17 positions the
    // doubling distances 1,2,4,8,16 give exactly five levels, and after the last level
    // g[5][k] is the carry into bit k.
    logic [ADDER_W:0] g [0:5];
    logic [ADDER_W:0] p [0:5];

    always_comb begin
        for (int l = 0; l <= 5; l++) begin
            g[l] = '0;
            p[l] = '0;
        end
        for (int k = 1; k <= ADDER_W; k++) begin
            g[0][k] = a[k-1] & b[k-1];
            p[0][k] = a[k-1] ^ b[k-1];
        end
        for (int l = 1; l <= 5; l++) begin
            for (int k = 0; k <= ADDER_W; k++) begin
                if (k >= (1 << (l - 1))) begin
                    g[l][k] = g[l-1][k] | (p[l-1][k] & g[l-1][k - (1 << (l - 1))]);
                    p[l][k] = p[l-1][k] & p[l-1][k - (1 << (l - 1))];
                end else begin
                    g[l][k] = g[l-1][k];
                    p[l][k] = p[l-1][k];
                end
            end
        end
        sum = '0;
        for (int i = 0; i < ADDER_W; i++) begin
            sum[i] = p[0][i+1] ^ g[5][i];
        end
        cout = g[5][ADDER_W];
    end

endmodule

// File: rtl/prefix_adder_rr_arbiter.sv
// Round-robin arbiter sharing one 16-bit prefix adder among NREQ requesters; result held in one output register.
// Latency: 1 cycle from accepted request to rsp_valid.
// Backpressure: req_ready all-zero while the result register is full and rsp_ready is low; full-rate pass-through otherwise.
// Ports: clk, rst_n; req_valid/req_ready/req_a/req_b per requester (16-bit lanes packed);
//        rsp_valid/rsp_ready/rsp_sum/rsp_cout/rsp_id result; op_count issued-operation counter.
module prefix_adder_rr_arbiter
    import prefix_adder_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*ADDER_W-1:0] req_a,
    input  logic [NREQ*ADDER_W-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ADDER_W-1:0]      rsp_sum,
    output logic                    rsp_cout,
    output logic [IDW-1:0]          rsp_id,
    output logic [CNTW-1:0]         op_count
);

    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     ptr_nxt;
    logic               can_issue;
    logic               grant;
    pick_t              pick;
    logic [ADDER_W-1:0] core_a;
    logic [ADDER_W-1:0] core_b;
    logic [ADDER_W-1:0] core_sum;
    logic               core_cout;

    // Register may be refilled in the same cycle it drains.
    assign can_issue = !rsp_valid || rsp_ready;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), NREQ);
        winner    = IDW'(pick.idx);
        grant     = can_issue && pick.found;
        req_ready = '0;
        core_a    = '0;
        core_b    = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
            core_a            = req_a[winner*ADDER_W +: ADDER_W];
            core_b            = req_b[winner*ADDER_W +: ADDER_W];
        end
        ptr_nxt = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    adder_16b_5l u_core (
        .a    (core_a),
        .b    (core_b),
        .sum  (core_sum),
        .cout (core_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
            op_count  <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= core_sum;
            rsp_cout  <= core_cout;
            rsp_id    <= winner;
            rr_ptr    <= ptr_nxt;
            op_count  <= op_count + 1'b1;
        end else if (rsp_ready) begin
            // Drain only; data fields keep their last value.
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prefix_adder_rr_arbiter.sv
module tb_prefix_adder_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a;
    logic [NREQ*16-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_sum;
    logic              rsp_cout;
    logic [IDW-1:0]    rsp_id;
    logic [CNTW-1:0]   op_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    typedef struct {
        logic [16:0]    sumc;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sb_q[$];

    prefix_adder_rr_arbiter #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Inputs only change at posedge+1, so the negedge sample is what the next edge sees.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_result", {13'd0, rsp_cout, rsp_sum, rsp_id}, {13'd0, e.sumc, e.id});
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.sumc = {1'b0, req_a[i*16 +: 16]} + {1'b0, req_b[i*16 +: 16]};
                    e.id   = IDW'(i);
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 16'h0100, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 16'h0000, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 16'h5555, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[6] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0};

        req_a = '0;
        req_b = '0;

        // Reset values and single request from requester 0.
        do_reset();
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_sum",   32'(rsp_sum),   32'd0);
        check("rst_rsp_cout",  32'(rsp_cout),  32'd0);
        check("rst_rsp_id",    32'(rsp_id),    32'd0);
        check("rst_op_count",  32'(op_count),  32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        set_req(0, 16'h00FF, 16'h0001);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t1_req_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_sum",   32'(rsp_sum),   32'h0100);
        check("t1_rsp_cout",  32'(rsp_cout),  32'd0);
        check("t1_rsp_id",    32'(rsp_id),    32'd0);
        check("t1_op_count",  32'(op_count),  32'd1);

        // Table: back-to-back single requests, rotating requester.
        for (int k = 0; k <= 8; k++) begin
            tick();
            req_valid = '0;
            if (k < 8) begin
                set_req(k % NREQ, vecs[k].a, vecs[k].b);
                req_valid[k % NREQ] = 1'b1;
            end
            @(negedge clk);
            if (k > 0) begin
                check("tbl_sum",  32'(rsp_sum),  32'(vecs[k-1].exp_sum));
                check("tbl_cout", 32'(rsp_cout), 32'(vecs[k-1].exp_cout));
                check("tbl_id",   32'(rsp_id),   32'((k - 1) % NREQ));
            end
            if (k < 8) check("tbl_ready", 32'(req_ready), 32'(1) << (k % NREQ));
        end

        // All four valid: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'(32'h1000 * (i + 1)), 16'(i + 1));
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1) << (c % NREQ));
            if (c > 0) check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        check("rr_op_count", 32'(op_count), 32'd5);
        check("rr_last_id",  32'(rsp_id),   32'd0);

        // Backpressure: result held 3 cycles while req2 waits.
        do_reset();
        set_req(0, 16'h0102, 16'h0304);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b0100;
        set_req(2, 16'hF000, 16'h2000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_sum",   32'(rsp_sum),   32'h0406);
            check("bp_op_count",  32'(op_count),  32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("bp_new_valid", 32'(rsp_valid), 32'd1);
        check("bp_new_id",    32'(rsp_id),    32'd2);
        check("bp_new_sum",   32'(rsp_sum),   32'h1000);
        check("bp_new_cout",  32'(rsp_cout),  32'd1);

        // Reset while a result is held and requests are pending.
        tick();
        set_req(3, 16'h0011, 16'h0022);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        tick();
        req_valid = 4'b1010;
        @(negedge clk);
        check("mr_pre_valid", 32'(rsp_valid), 32'd1);
        tick();
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_op_count",  32'(op_count),  32'd0);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1011;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mr_prio0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("mr_id0", 32'(rsp_id), 32'd0);

        // Counter wrap.
        tick();
        force dut.op_count = 16'hFFFF;
        set_req(1, 16'h0001, 16'h0002);
        req_valid = 4'b0010;
        #1;
        release dut.op_count;
        @(negedge clk);
        check("wrap_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("wrap_op_count",  32'(op_count),  32'd0);
        check("wrap_rsp_valid", 32'(rsp_valid), 32'd1);

        // Drain and confirm every accepted request produced exactly one result.
        repeat (3) @(negedge clk);
        check("drain_valid", 32'(rsp_valid), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
